// File: rtl/segre_pkg.sv
// Shared types and constants for the segre fetch path.
// The fetch queue entry pairs an instruction word with the PC it was fetched from.
package segre_pkg;

  localparam int unsigned ADDR_SIZE        = 32;
  localparam int unsigned WORD_SIZE        = 32;
  localparam int unsigned FQ_DEPTH_DEFAULT = 4;

  // addi x0, x0, 0
  localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    FULL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [ADDR_SIZE-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/segre_fetch_queue.sv
// Power-of-two FIFO of fetched {instr, pc} entries with push/pop/flush and occupancy.
// Flush wins over push and pop; the caller never pushes into a full queue without popping.
module segre_fetch_queue
  import segre_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rsn,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fq_entry_t     i_data,
  output fq_entry_t     o_head,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fq_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/segre_fetch_unit.sv
// Instruction fetch: walks the PC through the icache, buffers hits in a small queue
// toward decode, stalls on misses and a full queue, and restarts on redirects.
module segre_fetch_unit
  import segre_pkg::*;
#(
  parameter int unsigned          FQ_DEPTH = FQ_DEPTH_DEFAULT,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  output logic                 icache_req_o,
  output logic [ADDR_SIZE-1:0] icache_addr_o,
  input  logic                 icache_hit_i,
  input  logic [WORD_SIZE-1:0] icache_instr_i,
  input  logic                 redirect_i,
  input  logic [ADDR_SIZE-1:0] redirect_pc_i,
  output logic                 instr_valid_o,
  output logic [WORD_SIZE-1:0] instr_o,
  output logic [ADDR_SIZE-1:0] instr_pc_o,
  input  logic                 decode_ready_i,
  output logic [31:0]          miss_cycles_o
);

  localparam int unsigned    CW      = $clog2(FQ_DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FQ_DEPTH);

  fetch_state_e         r_state;
  fetch_state_e         w_next_state;
  logic [ADDR_SIZE-1:0] r_pc;
  logic                 r_req;
  logic [31:0]          r_miss_cycles;

  logic                 w_valid;
  logic                 w_pop_req;
  logic                 w_pop;
  logic                 w_push;
  logic [CW-1:0]        w_count;
  logic [CW-1:0]        w_next_count;
  fq_entry_t            w_head;
  fq_entry_t            w_push_data;
  logic                 w_unused_redirect_bits;

  // Redirect targets are word aligned, so the low two bits are dropped.
  assign w_unused_redirect_bits = ^redirect_pc_i[1:0];

  assign w_valid     = (w_count != {CW{1'b0}});
  assign w_pop_req   = w_valid && decode_ready_i;
  assign w_pop       = w_pop_req && !redirect_i;
  assign w_push      = r_req && icache_hit_i && ((w_count < DEPTH_C) || w_pop_req) && !redirect_i;
  assign w_push_data = '{instr: icache_instr_i, pc: r_pc};

  segre_fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .CW    (CW)
  ) u_queue (
    .i_clk   (clk_i),
    .i_rsn   (rsn_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Occupancy after this edge, used to enter and leave FULL.
  always_comb begin
    w_next_count = w_count;
    case ({w_push, w_pop})
      2'b10:   w_next_count = w_count + CW'(1);
      2'b01:   w_next_count = w_count - CW'(1);
      default: w_next_count = w_count;
    endcase
  end

  // Next fetch state.
  always_comb begin
    w_next_state = r_state;
    if (redirect_i) begin
      w_next_state = RUN;
    end else if (w_next_count == DEPTH_C) begin
      w_next_state = FULL;
    end else begin
      case (r_state)
        RUN:     w_next_state = (r_req && !icache_hit_i) ? MISS : RUN;
        MISS:    w_next_state = icache_hit_i ? RUN : MISS;
        FULL:    w_next_state = RUN;
        default: w_next_state = RUN;
      endcase
    end
  end

  // State, PC, request and miss statistics; the request is held low throughout reset.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_req         <= 1'b0;
      r_miss_cycles <= 32'h0000_0000;
    end else begin
      r_state <= w_next_state;
      r_req   <= (w_next_state != FULL);
      if (redirect_i) begin
        r_pc <= {redirect_pc_i[ADDR_SIZE-1:2], 2'b00};
      end else if (w_push) begin
        r_pc <= r_pc + ADDR_SIZE'(32'd4);
      end else begin
        r_pc <= r_pc;
      end
      if ((r_state == MISS) && (r_miss_cycles != 32'hFFFF_FFFF)) begin
        r_miss_cycles <= r_miss_cycles + 32'd1;
      end else begin
        r_miss_cycles <= r_miss_cycles;
      end
    end
  end

  // Decode-side view of the queue head; an empty queue presents a NOP at PC 0.
  always_comb begin
    if (w_valid) begin
      instr_o    = w_head.instr;
      instr_pc_o = w_head.pc;
    end else begin
      instr_o    = NOP_INSTR;
      instr_pc_o = '0;
    end
  end

  assign instr_valid_o = w_valid;
  assign icache_req_o  = r_req;
  assign icache_addr_o = r_pc;
  assign miss_cycles_o = r_miss_cycles;

endmodule
